// File: rtl/uart_rx_framer.sv
// -----------------------------------------------------------------------------
// uart_rx_framer
//
// Serial receive front end for the host loader path. The asynchronous RX line
// is synchronized, then framed as 8N1 (or 8E1 when UART_RX_PARITY_EN is
// defined). Each completed good byte lands in a one-entry holding register
// drained through a ready/valid handshake. Framing errors, parity errors and
// overruns are reported as single-cycle pulses.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined     : 8E1 framing, PARITY state, parity_error port present
//   not defined : 8N1 framing, no PARITY state, no parity_error port
//
// Parameters:
//   BAUD_RATE  - line rate in bits/s
//   CLOCK_FREQ - clock frequency in Hz
//   CLOCK_FREQ / BAUD_RATE must be at least 4.
//
// Ports:
//   clock          - single rising-edge clock
//   reset          - asynchronous active-low reset
//   serial_in      - asynchronous RX line, idle high
//   data_out       - received byte, LSB = first data bit
//   data_out_valid - holding register full
//   data_out_ready - consumer accepts data_out when valid && ready
//   framing_error  - 1-cycle pulse: stop bit sampled 0
//   overrun        - 1-cycle pulse: good byte dropped, holding register full
//   parity_error   - 1-cycle pulse: even-parity mismatch (macro only)
// -----------------------------------------------------------------------------
module uart_rx_framer #(
    parameter int BAUD_RATE  = 115_200,
    parameter int CLOCK_FREQ = 125_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_error
`endif
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
    localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity holds when data bits plus the parity bit XOR to zero.
    function automatic logic even_parity_ok(input logic [7:0] data, input logic par_bit);
        return ~(^{data, par_bit});
    endfunction
`endif

    // Synchronizer flops; both idle high so a reset looks like an idle line.
    logic sync1_r;
    logic rx_s;

    // FSM / datapath state and next-state values.
    state_t     state_r;
    state_t     state_nxt;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt;
    logic [2:0] bit_idx_r;
    logic [2:0] bit_idx_nxt;
    logic [7:0] shift_r;
    logic [7:0] shift_nxt;
`ifdef UART_RX_PARITY_EN
    logic       par_bit_r;
    logic       par_bit_nxt;
`endif

    // Per-cycle stop-sample outcomes.
    logic byte_good_s;
    logic frame_err_s;
    logic par_err_s;
    logic load_s;
    logic drop_s;

    // Two-flop synchronizer on the asynchronous RX line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_r <= serial_in;
            rx_s    <= sync1_r;
        end
    end

    // FSM and framing datapath state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_bit_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt;
            cnt_r     <= cnt_nxt;
            bit_idx_r <= bit_idx_nxt;
            shift_r   <= shift_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit_r <= par_bit_nxt;
`endif
        end
    end

    // Next-state logic: START waits half a bit, later states sample at mid-bit.
    always_comb begin
        state_nxt   = state_r;
        cnt_nxt     = cnt_r;
        bit_idx_nxt = bit_idx_r;
        shift_nxt   = shift_r;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt = par_bit_r;
`endif
        byte_good_s = 1'b0;
        frame_err_s = 1'b0;
        par_err_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt = ST_START;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_START: begin
                if (cnt_r == SAMPLE_LAST) begin
                    cnt_nxt = CNT_ZERO;
                    if (!rx_s) begin
                        state_nxt   = ST_DATA;
                        bit_idx_nxt = 3'd0;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_r == SYMBOL_LAST) begin
                    cnt_nxt   = CNT_ZERO;
                    // Shift in at the MSB so the first (LSB) bit ends at bit 0.
                    shift_nxt = {rx_s, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == SYMBOL_LAST) begin
                    cnt_nxt     = CNT_ZERO;
                    par_bit_nxt = rx_s;
                    state_nxt   = ST_STOP;
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
`endif

            ST_STOP: begin
                if (cnt_r == SYMBOL_LAST) begin
                    // Return to IDLE at mid-stop so a following start edge
                    // inside the second half of the stop bit is not missed.
                    cnt_nxt     = CNT_ZERO;
                    state_nxt   = ST_IDLE;
                    frame_err_s = ~rx_s;
`ifdef UART_RX_PARITY_EN
                    par_err_s   = ~even_parity_ok(shift_r, par_bit_r);
`else
                    par_err_s   = 1'b0;
`endif
                    byte_good_s = rx_s & ~par_err_s;
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_nxt   = ST_IDLE;
                cnt_nxt     = CNT_ZERO;
                bit_idx_nxt = 3'd0;
            end
        endcase
    end

    // Holding register admission: load when empty or being drained this cycle.
    always_comb begin
        load_s = 1'b0;
        drop_s = 1'b0;
        if (byte_good_s) begin
            load_s = ~data_out_valid | data_out_ready;
            drop_s = data_out_valid & ~data_out_ready;
        end else begin
            load_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Holding register, handshake flag and registered status pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
            framing_error  <= 1'b0;
            overrun        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error   <= 1'b0;
`endif
        end else begin
            if (load_s) begin
                data_out <= shift_r;
            end else begin
                data_out <= data_out;
            end

            if (load_s) begin
                data_out_valid <= 1'b1;
            end else if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end else begin
                data_out_valid <= data_out_valid;
            end

            framing_error <= frame_err_s;
            overrun       <= drop_s;
`ifdef UART_RX_PARITY_EN
            parity_error  <= par_err_s;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_framer
//
// Self-checking bench for uart_rx_framer with BAUD_RATE=1, CLOCK_FREQ=16
// (16 clocks per bit). Expected bytes are pushed to a scoreboard queue when a
// frame is sent and popped by a monitor when the DUT hands a byte over.
// -----------------------------------------------------------------------------
module tb_uart_rx_framer;

    localparam int BIT_CYC = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LATENCY = 2 + 8 + 10 * BIT_CYC + 1;
`else
    localparam int LATENCY = 2 + 8 + 9 * BIT_CYC + 1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb_q[$];

    int vcyc    = 0;
    int acc_cnt = 0;
    int fe_cnt  = 0;
    int ov_cnt  = 0;
    int pe_cnt  = 0;

    uart_rx_framer #(
        .BAUD_RATE (1),
        .CLOCK_FREQ(16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .framing_error (framing_error),
        .overrun       (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error  (parity_error)
`endif
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: counts pulses/valid cycles and scores each accepted byte.
    always @(negedge clock) begin
        if (data_out_valid) vcyc++;
        if (framing_error) fe_cnt++;
        if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_error) pe_cnt++;
`endif
        if (data_out_valid && data_out_ready) begin
            acc_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_byte", {24'd0, data_out}, 32'hFFFF_FFFF);
            end else begin
                check_eq("rx_byte", {24'd0, data_out}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    // Hard stop if the run ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycles(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (BIT_CYC) @(posedge clock);
        #1;
    endtask

    // One frame with a correct parity bit (when parity is compiled in).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_bit);
        serial_in = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    // One frame with an explicit parity bit value.
    task automatic send_frame_par(input logic [7:0] d, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par_bit);
        drive_bit(1'b1);
        serial_in = 1'b1;
    endtask
`endif

    initial begin
        int lat;
        int v0;
        int fe0;
        int ov0;
        int acc0;
        logic [7:0] pats [4];
        pats = '{8'h00, 8'hFF, 8'h55, 8'h80};

        reset          = 1'b0;
        serial_in      = 1'b1;
        data_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_data", {24'd0, data_out}, 32'h0);
        check_eq("rst_valid", {31'd0, data_out_valid}, 32'h0);
        check_eq("rst_fe", {31'd0, framing_error}, 32'h0);
        check_eq("rst_ov", {31'd0, overrun}, 32'h0);
        reset = 1'b1;
        idle_cycles(20);

        // 0xA5: value, latency, single valid cycle, no errors.
        v0 = vcyc;
        lat = 0;
        sb_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 1; i <= 250; i++) begin
                    @(posedge clock);
                    #1;
                    if (data_out_valid && lat == 0) lat = i;
                end
            end
        join
        idle_cycles(10);
        check_eq("latency", lat, LATENCY);
        check_eq("valid_width", vcyc - v0, 1);
        check_eq("a5_no_fe", fe_cnt, 0);
        check_eq("a5_no_ov", ov_cnt, 0);

        // Further data patterns.
        for (int p = 0; p < 4; p++) begin
            sb_q.push_back(pats[p]);
            send_frame(pats[p], 1'b1);
            idle_cycles(10);
        end

        // Short low glitch: silently ignored.
        v0 = vcyc;
        fe0 = fe_cnt;
        serial_in = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        idle_cycles(60);
        check_eq("glitch_no_valid", vcyc - v0, 0);
        check_eq("glitch_no_fe", fe_cnt - fe0, 0);

        // Framing error on 0x3C, then 0x11 received cleanly.
        v0 = vcyc;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        idle_cycles(40);
        check_eq("fe_pulse", fe_cnt - fe0, 1);
        check_eq("fe_no_valid", vcyc - v0, 0);
        v0 = vcyc;
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        idle_cycles(20);
        check_eq("after_fe_valid", vcyc - v0, 1);

        // Overrun: ready low, 0x01 then 0x02 back-to-back.
        data_out_ready = 1'b0;
        ov0 = ov_cnt;
        sb_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        idle_cycles(5);
        check_eq("ov_pulse", ov_cnt - ov0, 1);
        check_eq("ov_held_data", {24'd0, data_out}, 32'h01);
        check_eq("ov_held_valid", {31'd0, data_out_valid}, 32'h1);
        acc0 = acc_cnt;
        idle_cycles(30);
        check_eq("ov_stable", {24'd0, data_out}, 32'h01);
        data_out_ready = 1'b1;
        idle_cycles(5);
        check_eq("ov_one_accept", acc_cnt - acc0, 1);
        check_eq("ov_drained", {31'd0, data_out_valid}, 32'h0);

        // Reset during data bit 4 of 0xFF.
        v0 = vcyc;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * BIT_CYC + 8) @(posedge clock);
                #3;
                reset = 1'b0;
                #1;
                check_eq("midrst_data", {24'd0, data_out}, 32'h0);
                check_eq("midrst_valid", {31'd0, data_out_valid}, 32'h0);
                repeat (3) @(posedge clock);
                #1;
                reset = 1'b1;
            end
        join
        idle_cycles(40);
        check_eq("midrst_no_valid", vcyc - v0, 0);
        check_eq("midrst_no_fe", fe_cnt - fe0, 0);
        check_eq("midrst_no_ov", ov_cnt - ov0, 0);
        v0 = vcyc;
        sb_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        idle_cycles(20);
        check_eq("after_rst_valid", vcyc - v0, 1);

`ifdef UART_RX_PARITY_EN
        // Wrong parity on 0x07 is dropped; correct parity is received.
        v0 = vcyc;
        send_frame_par(8'h07, 1'b0);
        idle_cycles(20);
        check_eq("pe_pulse", pe_cnt, 1);
        check_eq("pe_no_valid", vcyc - v0, 0);
        sb_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1);
        idle_cycles(20);
        check_eq("pe_ok_valid", vcyc - v0, 1);
        check_eq("pe_no_extra", pe_cnt, 1);
`endif

        idle_cycles(10);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
